// File: rtl/frame_dispatch_queue_if.sv
// Bus bundle between the frame builder / EndDevice side and frame_dispatch_queue.
// The master drives buttons, frame fields and port busy flags; the slave (the
// queue) drives the per-port transmit slices, strobes and status flags.
interface frame_dispatch_queue_if #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 4,
  parameter int PAYLOAD_W = 4
);
  localparam int FRAME_W = 4 + 2 * ADDR_W + PAYLOAD_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic                         add_btn;
  logic                         send_btn;
  logic                         err_clr;
  logic [ADDR_W-1:0]            dst_addr;
  logic [ADDR_W-1:0]            src_addr;
  logic [PAYLOAD_W-1:0]         payload;
  logic [NUM_PORTS-1:0]         port_busy;
  logic [NUM_PORTS*FRAME_W-1:0] tx_frame;
  logic [NUM_PORTS-1:0]         tx_valid;
  logic                         burst_start;
  logic [CNT_W-1:0]             count;
  logic                         full;
  logic                         empty;
  logic                         dispatching;
  logic                         drop_err;

  modport master (
    output add_btn, send_btn, err_clr, dst_addr, src_addr, payload, port_busy,
    input  tx_frame, tx_valid, burst_start, count, full, empty, dispatching, drop_err
  );

  modport slave (
    input  add_btn, send_btn, err_clr, dst_addr, src_addr, payload, port_busy,
    output tx_frame, tx_valid, burst_start, count, full, empty, dispatching, drop_err
  );
endinterface

// File: rtl/frame_dispatch_queue.sv
// frame_dispatch_queue: captures user-built frames into a DEPTH-entry circular
// FIFO (one per add-button press) and, on a send-button press, releases the
// frames queued at that moment one at a time to the per-port EndDevice
// transmit inputs, honouring port busy and an inter-frame gap.
// Optional build macro HOL_TIMEOUT_EN: drops a head frame whose port stays
// busy for HOL_TIMEOUT consecutive cycles instead of waiting forever.
module frame_dispatch_queue #(
  parameter int               NUM_PORTS  = 4,
  parameter int               DEPTH      = 8,
  parameter int               ADDR_W     = 4,
  parameter int               PAYLOAD_W  = 4,
  parameter logic [3:0]       SFD        = 4'b0101,
  parameter logic [ADDR_W-1:0] MAC_BASE  = 4'hA,
  parameter int               GAP_CYCLES = 20
`ifdef HOL_TIMEOUT_EN
  ,
  parameter int               HOL_TIMEOUT = 1024
`endif
) (
  input  logic                  FPGA_CLK,
  input  logic                  sys_rst,
  frame_dispatch_queue_if.slave bus
);

  localparam int FRAME_W = 4 + 2 * ADDR_W + PAYLOAD_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PIDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ZERO   = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0]  GAP_ONE    = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W:0]   PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

`ifdef HOL_TIMEOUT_EN
  localparam int HOL_W = (HOL_TIMEOUT > 1) ? $clog2(HOL_TIMEOUT) : 1;
  localparam logic [HOL_W-1:0] HOL_ZERO = {HOL_W{1'b0}};
  localparam logic [HOL_W-1:0] HOL_ONE  = HOL_W'(1);
  localparam logic [HOL_W-1:0] HOL_LAST = HOL_W'(HOL_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Registered state
  state_e                       state_q, state_d;
  logic                         add_d1_q, send_d1_q;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [CNT_W-1:0]             burst_len_q, burst_len_d;
  logic [GAP_W-1:0]             gap_cnt_q, gap_cnt_d;
  logic [NUM_PORTS*FRAME_W-1:0] tx_frame_q, tx_frame_d;
  logic [NUM_PORTS-1:0]         tx_valid_q, tx_valid_d;
  logic                         burst_start_q, burst_start_d;
  logic                         drop_err_q, drop_err_d;
`ifdef HOL_TIMEOUT_EN
  logic [HOL_W-1:0]             hol_cnt_q, hol_cnt_d;
`endif

  // Queue storage: frame image plus the destination port it leaves on
  logic [FRAME_W-1:0]           mem_frame_q [DEPTH];
  logic [PIDX_W-1:0]            mem_port_q  [DEPTH];

  // Combinational helpers
  logic                         add_trig_s, send_trig_s;
  logic [ADDR_W:0]              src_off_s;
  logic                         src_valid_s;
  logic [PIDX_W-1:0]            src_idx_s;
  logic [FRAME_W-1:0]           new_frame_s;
  logic                         push_s, add_drop_s;
  logic                         pop_s, hol_drop_s;
  logic [FRAME_W-1:0]           head_frame_s;
  logic [PIDX_W-1:0]            head_port_s;
  logic                         head_busy_s;

  // One trigger per press: current level high, previous level low
  assign add_trig_s  = bus.add_btn  & ~add_d1_q;
  assign send_trig_s = bus.send_btn & ~send_d1_q;

  // Source MAC to port index; the extra MSB catches src_addr below MAC_BASE
  assign src_off_s   = {1'b0, bus.src_addr} - {1'b0, MAC_BASE};
  assign src_valid_s = ~src_off_s[ADDR_W] & (src_off_s < PORT_LIMIT);
  assign src_idx_s   = src_off_s[PIDX_W-1:0];
  assign new_frame_s = {SFD, bus.dst_addr, bus.src_addr, bus.payload};

  // Full is judged on the pre-cycle count, so a same-cycle pop cannot rescue a push
  assign push_s      = add_trig_s & src_valid_s & (count_q != CNT_FULL);
  assign add_drop_s  = add_trig_s & ~push_s;

  assign head_frame_s = mem_frame_q[rd_ptr_q];
  assign head_port_s  = mem_port_q[rd_ptr_q];
  assign head_busy_s  = bus.port_busy[head_port_s];

  // Burst controller: next state, dispatch strobes and head pop decision
  always_comb begin
    state_d       = state_q;
    burst_len_d   = burst_len_q;
    gap_cnt_d     = gap_cnt_q;
    burst_start_d = 1'b0;
    tx_valid_d    = {NUM_PORTS{1'b0}};
    tx_frame_d    = tx_frame_q;
    pop_s         = 1'b0;
    hol_drop_s    = 1'b0;
`ifdef HOL_TIMEOUT_EN
    hol_cnt_d     = HOL_ZERO;
`endif
    case (state_q)
      ST_IDLE: begin
        // The burst covers only what is queued now; later adds wait for the next send
        if (send_trig_s && (count_q != CNT_ZERO)) begin
          state_d       = ST_ARM;
          burst_start_d = 1'b1;
          burst_len_d   = count_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        // One quiet cycle lets the switch clear its FIFOs and LEDs
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!head_busy_s) begin
          tx_valid_d[head_port_s]                      = 1'b1;
          tx_frame_d[head_port_s*FRAME_W +: FRAME_W]   = head_frame_s;
          pop_s                                        = 1'b1;
        end else begin
`ifdef HOL_TIMEOUT_EN
          if (hol_cnt_q == HOL_LAST) begin
            pop_s      = 1'b1;
            hol_drop_s = 1'b1;
          end else begin
            hol_cnt_d = hol_cnt_q + HOL_ONE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end
        if (pop_s) begin
          burst_len_d = burst_len_q - CNT_ONE;
          gap_cnt_d   = GAP_ZERO;
          state_d     = (burst_len_q == CNT_ONE) ? ST_IDLE : ST_GAP;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = GAP_ZERO;
          state_d   = ST_ISSUE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_ONE;
          state_d   = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Queue pointers, occupancy and the sticky drop flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_err_d = drop_err_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as err_clr must stay visible
    if (add_drop_s || hol_drop_s) begin
      drop_err_d = 1'b1;
    end else if (bus.err_clr) begin
      drop_err_d = 1'b0;
    end else begin
      drop_err_d = drop_err_q;
    end
  end

  // Control and output registers; reset discards any burst in flight
  always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      add_d1_q      <= 1'b0;
      send_d1_q     <= 1'b0;
      wr_ptr_q      <= PTR_ZERO;
      rd_ptr_q      <= PTR_ZERO;
      count_q       <= CNT_ZERO;
      burst_len_q   <= CNT_ZERO;
      gap_cnt_q     <= GAP_ZERO;
      tx_frame_q    <= {(NUM_PORTS*FRAME_W){1'b0}};
      tx_valid_q    <= {NUM_PORTS{1'b0}};
      burst_start_q <= 1'b0;
      drop_err_q    <= 1'b0;
`ifdef HOL_TIMEOUT_EN
      hol_cnt_q     <= HOL_ZERO;
`endif
    end else begin
      state_q       <= state_d;
      add_d1_q      <= bus.add_btn;
      send_d1_q     <= bus.send_btn;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      burst_len_q   <= burst_len_d;
      gap_cnt_q     <= gap_cnt_d;
      tx_frame_q    <= tx_frame_d;
      tx_valid_q    <= tx_valid_d;
      burst_start_q <= burst_start_d;
      drop_err_q    <= drop_err_d;
`ifdef HOL_TIMEOUT_EN
      hol_cnt_q     <= hol_cnt_d;
`endif
    end
  end

  // Queue entry write on an accepted add
  always_ff @(posedge FPGA_CLK or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_frame_q[i] <= {FRAME_W{1'b0}};
        mem_port_q[i]  <= {PIDX_W{1'b0}};
      end
    end else if (push_s) begin
      mem_frame_q[wr_ptr_q] <= new_frame_s;
      mem_port_q[wr_ptr_q]  <= src_idx_s;
    end
  end

  assign bus.tx_frame    = tx_frame_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.burst_start = burst_start_q;
  assign bus.count       = count_q;
  assign bus.full        = (count_q == CNT_FULL);
  assign bus.empty       = (count_q == CNT_ZERO);
  assign bus.dispatching = (state_q != ST_IDLE);
  assign bus.drop_err    = drop_err_q;

endmodule

// File: tb/tb_frame_dispatch_queue.sv
// Directed bench for frame_dispatch_queue with a scoreboard of expected
// dispatches (port + frame) filled as frames are added and drained by a
// negedge monitor whenever tx_valid fires.
module tb_frame_dispatch_queue;
  localparam int FW = 16;

  typedef struct {
    int          port;
    logic [15:0] frame;
  } exp_t;

  logic FPGA_CLK = 1'b0;
  logic sys_rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   tx_count = 0;
  int   tx_cyc[$];
  exp_t sb[$];
  int   base;

  always #5 FPGA_CLK = ~FPGA_CLK;

  frame_dispatch_queue_if #(.NUM_PORTS(4), .DEPTH(8), .ADDR_W(4), .PAYLOAD_W(4)) bus ();

  frame_dispatch_queue #(
    .GAP_CYCLES(20)
`ifdef HOL_TIMEOUT_EN
    , .HOL_TIMEOUT(16)
`endif
  ) dut (
    .FPGA_CLK (FPGA_CLK),
    .sys_rst  (sys_rst),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge FPGA_CLK) cyc <= cyc + 1;

  // Monitor: every dispatch must match the oldest expected frame
  always @(negedge FPGA_CLK) begin : mon
    exp_t e;
    if (bus.tx_valid !== 4'b0000) begin
      check("tx_onehot", 64'($onehot(bus.tx_valid)), 64'd1);
      if (sb.size() == 0) begin
        check("tx_unexpected", 64'(bus.tx_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("tx_port", 64'(bus.tx_valid), 64'(4'b0001 << e.port));
        check("tx_frame", 64'(bus.tx_frame[e.port*FW +: FW]), 64'(e.frame));
      end
      tx_count++;
      tx_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge FPGA_CLK);
    #1;
  endtask

  task automatic press_add(input logic [3:0] dst, input logic [3:0] src,
                           input logic [3:0] pl, input bit accept);
    bus.dst_addr = dst;
    bus.src_addr = src;
    bus.payload  = pl;
    bus.add_btn  = 1'b1;
    if (accept) sb.push_back('{port: int'(src) - 10, frame: {4'b0101, dst, src, pl}});
    tick(1);
    bus.add_btn = 1'b0;
    tick(1);
  endtask

  task automatic press_send();
    bus.send_btn = 1'b1;
    tick(1);
    bus.send_btn = 1'b0;
    tick(1);
  endtask

  task automatic pulse_err_clr();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int k = 0;
    while (tx_count < target && k < budget) begin
      @(negedge FPGA_CLK);
      #1;
      k++;
    end
    check(tag, 64'(tx_count), 64'(target));
    @(posedge FPGA_CLK);
    #1;
  endtask

  initial begin
    sys_rst       = 1'b1;
    bus.add_btn   = 1'b0;
    bus.send_btn  = 1'b0;
    bus.err_clr   = 1'b0;
    bus.dst_addr  = 4'h0;
    bus.src_addr  = 4'h0;
    bus.payload   = 4'h0;
    bus.port_busy = 4'b0000;
    tick(3);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_disp", 64'(bus.dispatching), 64'd0);
    check("rst_txv", 64'(bus.tx_valid), 64'd0);
    check("rst_txf", 64'(bus.tx_frame), 64'd0);
    check("rst_drop", 64'(bus.drop_err), 64'd0);
    sys_rst = 1'b0;
    tick(1);

    // Single frame, exact latency from send to dispatch
    press_add(4'hC, 4'hA, 4'h5, 1'b1);
    check("t1_count", 64'(bus.count), 64'd1);
    check("t1_empty", 64'(bus.empty), 64'd0);
    bus.send_btn = 1'b1;
    tick(1);
    check("t1_bstart", 64'(bus.burst_start), 64'd1);
    check("t1_disp", 64'(bus.dispatching), 64'd1);
    bus.send_btn = 1'b0;
    tick(1);
    check("t1_bstart_pulse", 64'(bus.burst_start), 64'd0);
    check("t1_arm_txv", 64'(bus.tx_valid), 64'd0);
    tick(1);
    check("t1_txv", 64'(bus.tx_valid), 64'h1);
    check("t1_txf", 64'(bus.tx_frame[15:0]), 64'h5CA5);
    check("t1_count0", 64'(bus.count), 64'd0);
    check("t1_idle", 64'(bus.dispatching), 64'd0);
    tick(1);
    check("t1_txv_1cyc", 64'(bus.tx_valid), 64'd0);

    // Three frames B, B, D: FIFO order and GAP_CYCLES+1 spacing
    tx_cyc.delete();
    base = tx_count;
    press_add(4'h3, 4'hB, 4'h1, 1'b1);
    press_add(4'h4, 4'hB, 4'h2, 1'b1);
    press_add(4'h5, 4'hD, 4'h3, 1'b1);
    check("t2_count", 64'(bus.count), 64'd3);
    press_send();
    wait_tx(base + 3, 200, "t2_ntx");
    check("t2_gap01", 64'(tx_cyc[1] - tx_cyc[0]), 64'd21);
    check("t2_gap12", 64'(tx_cyc[2] - tx_cyc[1]), 64'd21);
    check("t2_hold0", 64'(bus.tx_frame[15:0]), 64'h5CA5);

    // Overfill: ninth add dropped, flag sticky until cleared
    base = tx_count;
    for (int i = 0; i < 8; i++) press_add(4'h1, 4'hA, 4'(i), 1'b1);
    check("t3_count8", 64'(bus.count), 64'd8);
    check("t3_full", 64'(bus.full), 64'd1);
    check("t3_nodrop", 64'(bus.drop_err), 64'd0);
    press_add(4'h1, 4'hA, 4'hF, 1'b0);
    check("t3_count_sat", 64'(bus.count), 64'd8);
    check("t3_drop", 64'(bus.drop_err), 64'd1);
    pulse_err_clr();
    check("t3_clr", 64'(bus.drop_err), 64'd0);
    press_send();
    wait_tx(base + 8, 400, "t3_ntx");
    check("t3_empty", 64'(bus.empty), 64'd1);

    // Invalid sources below and above the port range
    press_add(4'h0, 4'h3, 4'h0, 1'b0);
    check("t4_count", 64'(bus.count), 64'd0);
    check("t4_drop", 64'(bus.drop_err), 64'd1);
    pulse_err_clr();
    check("t4_clr", 64'(bus.drop_err), 64'd0);
    bus.src_addr = 4'hE;
    bus.add_btn  = 1'b1;
    bus.err_clr  = 1'b1;
    tick(1);
    bus.add_btn  = 1'b0;
    bus.err_clr  = 1'b0;
    tick(1);
    check("t4_drop_wins", 64'(bus.drop_err), 64'd1);
    check("t4_count_hi", 64'(bus.count), 64'd0);
    pulse_err_clr();

    // Head-of-line blocking on port 2
    base = tx_count;
    bus.port_busy = 4'b0100;
    press_add(4'h2, 4'hC, 4'h6, 1'b1);
    press_send();
    tick(30);
    check("t5_notx", 64'(tx_count), 64'(base));
`ifdef HOL_TIMEOUT_EN
    check("t5_hol_count", 64'(bus.count), 64'd0);
    check("t5_hol_drop", 64'(bus.drop_err), 64'd1);
    check("t5_hol_idle", 64'(bus.dispatching), 64'd0);
    void'(sb.pop_front());
    bus.port_busy = 4'b0000;
    pulse_err_clr();
`else
    check("t5_count", 64'(bus.count), 64'd1);
    check("t5_wait", 64'(bus.dispatching), 64'd1);
    bus.port_busy = 4'b0000;
    tick(1);
    check("t5_txv", 64'(bus.tx_valid), 64'h4);
    check("t5_count0", 64'(bus.count), 64'd0);
    tick(1);
`endif

    // Frame added mid-burst waits for the next send
    base = tx_count;
    press_add(4'h1, 4'hA, 4'h7, 1'b1);
    press_add(4'h2, 4'hB, 4'h8, 1'b1);
    press_send();
    wait_tx(base + 1, 50, "t6_first");
    press_add(4'h3, 4'hD, 4'h9, 1'b1);
    wait_tx(base + 2, 100, "t6_second");
    tick(5);
    check("t6_idle", 64'(bus.dispatching), 64'd0);
    check("t6_left", 64'(bus.count), 64'd1);
    tick(40);
    check("t6_no_extra", 64'(tx_count), 64'(base + 2));
    press_send();
    wait_tx(base + 3, 50, "t6_third");
    check("t6_count0", 64'(bus.count), 64'd0);

    // Asynchronous reset in the middle of a gap
    base = tx_count;
    press_add(4'h1, 4'hA, 4'h1, 1'b1);
    press_add(4'h2, 4'hB, 4'h2, 1'b1);
    press_send();
    wait_tx(base + 1, 50, "t7_first");
    tick(5);
    #2 sys_rst = 1'b1;
    #1;
    check("t7_txv", 64'(bus.tx_valid), 64'd0);
    check("t7_txf", 64'(bus.tx_frame), 64'd0);
    check("t7_count", 64'(bus.count), 64'd0);
    check("t7_disp", 64'(bus.dispatching), 64'd0);
    check("t7_bstart", 64'(bus.burst_start), 64'd0);
    check("t7_empty", 64'(bus.empty), 64'd1);
    sb.delete();
    tick(2);
    sys_rst = 1'b0;
    tick(30);
    check("t7_discard", 64'(tx_count), 64'(base + 1));
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
